ss_fetch_16b: RTL and testbench
===============================

Name: ss_fetch_16b

Overview:
- Fetch sequencer on the consuming side of the 16-bit PC register. Reads pc, fetches the instruction word from instruction memory over a req/ack handshake, and hands it downstream through a valid/ready handshake.
- Drives the PC register's add, b, pc_src and pc_write inputs, so the PC advances only when an instruction has been accepted.
- Sits between ss_pc_16b and the decode stage of the multicycle processor.

Parameters:
- PC_INC, 1, word increment applied to pc to form add.
- TIMEOUT, 15, maximum cycles in S_REQ without imem_ack before error; counter width 8 bits, legal range 1-255.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- pc  input  16  current PC from ss_pc_16b.
- add  output  16  sequential next-PC, pc + PC_INC mod 2^16, to ss_pc_16b.add.
- b  output  16  branch target, to ss_pc_16b.b.
- pc_src  output  1  0 = add, 1 = b, to ss_pc_16b.pc_src.
- pc_write  output  1  PC load strobe, to ss_pc_16b.pc_write.
- branch_taken  input  1  decode requests branch on the current accept.
- branch_target  input  16  branch destination.
- stall  input  1  inhibits starting a new fetch.
- imem_req  output  1  memory read request.
- imem_addr  output  16  read address.
- imem_ack  input  1  read data valid.
- imem_rdata  input  16  read data.
- ir  output  16  latched instruction.
- ir_valid  output  1  ir holds an unconsumed instruction.
- ir_ready  input  1  downstream accepts ir.
- fetch_err  output  1  sticky timeout flag.
- fetch_count  output  16  accepted-instruction count (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to S_IDLE; ir=0, ir_valid=0, imem_req=0, imem_addr=0, pc_write=0, pc_src=0, fetch_err=0, timeout counter=0, fetch_count=0.
  - Reset mid-fetch drops imem_req immediately; a later imem_ack is ignored.
- States S_IDLE, S_REQ, S_ISSUE, S_ERR, Moore-decoded except pc_write/pc_src.
- S_IDLE: all strobes 0. If stall=0, go to S_REQ next edge; otherwise stay.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1 (same-cycle ack legal): ir<=imem_rdata, counter cleared, go to S_ISSUE.
  - Otherwise counter increments. When counter reaches TIMEOUT with no ack, go to S_ERR.
  - stall is ignored once in S_REQ.
- S_ISSUE:
  - ir_valid=1; ir is stable.
  - Accept cycle = ir_valid & ir_ready. In the accept cycle (combinational):
    - pc_write=1 for exactly that cycle.
    - pc_src=branch_taken.
    - b=branch_target.
  - After accept: go to S_REQ if stall=0, else S_IDLE.
  - No accept: hold; pc_write=0.
- pc_src and b outside the accept cycle: pc_src=0, b=branch_target passthrough.
- add = pc + PC_INC at all times, truncated to 16 bits (0xFFFF + 1 -> 0x0000).
- Latency: ack in cycle N gives ir_valid in cycle N+1. Accept in cycle M gives updated pc and imem_req in cycle M+1. Best case is one instruction per 2 cycles.
- imem_ack outside S_REQ is ignored.
- S_ERR:
  - fetch_err=1, imem_req=0, ir_valid=0, pc_write=0.
  - Exit only via reset.
- branch_taken outside the accept cycle has no effect.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every accept cycle, wraps 0xFFFF -> 0x0000, and is cleared by reset.
- Undefined: fetch_count is tied to 0 and no counter flops are synthesized; the port is always present.

Test Plan:
- Reset with pc=0x0000, stall=0, imem_ack=1 from the 2nd cycle, rdata=0x1234, ir_ready=1 -> imem_req=1 with addr 0x0000; next cycle ir=0x1234, ir_valid=1, pc_write=1, pc_src=0, add=0x0001.
- Accept with branch_taken=1, branch_target=0x000F -> pc_src=1, b=0x000F, pc_write=1; next fetch addr 0x000F.
- Hold ir_ready=0 for 5 cycles in S_ISSUE -> ir_valid stays 1, ir unchanged, pc_write=0 all 5 cycles; accept on 6th.
- imem_ack held 0 with TIMEOUT=15 -> after 15 S_REQ cycles fetch_err=1, imem_req=0; later acks ignored; reset clears.
- pc=0xFFFF -> add=0x0000. stall=1 at accept -> S_IDLE, imem_req=0 until stall=0.
- Reset asserted mid-S_REQ -> imem_req=0 immediately. With FETCH_PERF_CNT_EN, 3 accepts -> fetch_count=3, then 0 after reset.

Source files
------------

// File: rtl/ss_fetch_16b.sv
// Fetch sequencer between ss_pc_16b and decode: fetches imem[pc] over req/ack and hands the word
// downstream over valid/ready. Optional accept counter enabled by `define FETCH_PERF_CNT_EN.
module ss_fetch_16b #(
    parameter int unsigned PC_INC  = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [15:0] add,
    output logic [15:0] b,
    output logic        pc_src,
    output logic        pc_write,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        fetch_err,
    output logic [15:0] fetch_count
);

    localparam logic [15:0] PcInc       = 16'(PC_INC);
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StIssue, StErr} state_e;

    state_e      state_q;
    logic [15:0] ir_q;
    logic [7:0]  tmo_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;
    logic        accept;

    // Status outputs are registered alongside the state so they never glitch on decode.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ir_q    <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!stall) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        tmo_q   <= '0;
                        state_q <= StIssue;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (tmo_q == TimeoutLast) begin
                        tmo_q   <= tmo_q + 8'd1;
                        state_q <= StErr;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                StIssue: begin
                    if (ir_ready) begin
                        valid_q <= 1'b0;
                        if (!stall) begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StErr: begin
                    // Terminal until reset.
                end
            endcase
        end
    end

    assign accept    = valid_q & ir_ready;
    assign pc_write  = accept;
    assign pc_src    = accept & branch_taken;
    assign b         = branch_target;
    assign add       = pc + PcInc;
    assign imem_req  = req_q;
    assign imem_addr = req_q ? pc : 16'h0000;
    assign ir        = ir_q;
    assign ir_valid  = valid_q;
    assign fetch_err = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ss_fetch_16b.sv
// Directed bench for ss_fetch_16b; includes a behavioural PC register closing the pc loop.
module tb_ss_fetch_16b;

    logic        CLK;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] add;
    logic [15:0] b;
    logic        pc_src;
    logic        pc_write;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic        fetch_err;
    logic [15:0] fetch_count;

    logic [15:0] pc_init;
    int          n_checks;
    int          n_err;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    ss_fetch_16b #(
        .PC_INC (1),
        .TIMEOUT(15)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .pc           (pc),
        .add          (add),
        .b            (b),
        .pc_src       (pc_src),
        .pc_write     (pc_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .fetch_err    (fetch_err),
        .fetch_count  (fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for ss_pc_16b.
    always @(posedge CLK or negedge reset) begin
        if (!reset) pc <= pc_init;
        else if (pc_write) pc <= pc_src ? b : add;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        pc_init       = 16'h0000;
        reset         = 1'b0;
        stall         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        ir_ready      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        #3;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        chk("rst_pcw", pc_write, 1'b0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_cnt", fetch_count, 16'h0000);
        tick();
        tick();
        reset = 1'b1;

        // First fetch from 0x0000, sequential accept.
        tick();
        #1;
        chk("f1_req", imem_req, 1'b1);
        chk("f1_addr", imem_addr, 16'h0000);
        chk("f1_valid0", ir_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        tick();
        imem_ack = 1'b0;
        #1;
        chk("f1_ir", ir, 16'h1234);
        chk("f1_valid", ir_valid, 1'b1);
        chk("f1_pcw", pc_write, 1'b1);
        chk("f1_pcsrc", pc_src, 1'b0);
        chk("f1_add", add, 16'h0001);
        chk("f1_req_issue", imem_req, 1'b0);
        tick();
        #1;
        chk("f2_addr", imem_addr, 16'h0001);
        chk("f2_valid0", ir_valid, 1'b0);
        chk("f2_pcw0", pc_write, 1'b0);

        // Branch on accept.
        imem_ack   = 1'b1;
        imem_rdata = 16'hABCD;
        tick();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h000F;
        #1;
        chk("br_ir", ir, 16'hABCD);
        chk("br_pcsrc", pc_src, 1'b1);
        chk("br_b", b, 16'h000F);
        chk("br_pcw", pc_write, 1'b1);
        tick();
        #1;
        chk("br_addr", imem_addr, 16'h000F);
        chk("br_pcsrc_noacc", pc_src, 1'b0);
        chk("br_pcw_noacc", pc_write, 1'b0);
        branch_taken = 1'b0;

        // Downstream holds off for 5 cycles, accepts on the 6th with stall raised.
        ir_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h5A5A;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", ir_valid, 1'b1);
            chk("hold_ir", ir, 16'h5A5A);
            chk("hold_pcw", pc_write, 1'b0);
            tick();
        end
        ir_ready = 1'b1;
        stall    = 1'b1;
        #1;
        chk("hold_acc_pcw", pc_write, 1'b1);
        chk("hold_acc_ir", ir, 16'h5A5A);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        #1;
        chk("stall_req", imem_req, 1'b0);
        chk("cnt3", fetch_count, PerfEn ? 16'd3 : 16'd0);
        tick();
        #1;
        chk("stall_ack_ignored", ir, 16'h5A5A);
        chk("stall_req2", imem_req, 1'b0);
        chk("stall_valid", ir_valid, 1'b0);
        imem_ack = 1'b0;
        stall    = 1'b0;
        tick();
        #1;
        chk("unstall_addr", imem_addr, 16'h0010);

        // No ack: 15 request cycles, then sticky error.
        for (int i = 0; i < 15; i++) begin
            chk("tmo_req", imem_req, 1'b1);
            chk("tmo_err0", fetch_err, 1'b0);
            tick();
            #1;
        end
        chk("tmo_err", fetch_err, 1'b1);
        chk("tmo_req_off", imem_req, 1'b0);
        chk("tmo_valid", ir_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        #1;
        chk("err_sticky", fetch_err, 1'b1);
        chk("err_ack_ignored", ir, 16'h5A5A);
        chk("err_pcw", pc_write, 1'b0);
        imem_ack = 1'b0;

        // Reset clears error; pc wraps in add.
        pc_init = 16'hFFFF;
        reset   = 1'b0;
        #1;
        chk("rst2_err", fetch_err, 1'b0);
        chk("rst2_cnt", fetch_count, 16'h0000);
        chk("rst2_ir", ir, 16'h0000);
        chk("add_wrap", add, 16'h0000);
        stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        #1;
        chk("idle_stall_req", imem_req, 1'b0);
        stall = 1'b0;
        tick();
        #1;
        chk("wrap_req", imem_req, 1'b1);
        chk("wrap_addr", imem_addr, 16'hFFFF);

        // Reset mid-request drops req at once; a later ack is ignored.
        reset = 1'b0;
        #1;
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_addr", imem_addr, 16'h0000);
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        #1;
        reset = 1'b1;
        tick();
        #1;
        chk("midrst_ir", ir, 16'h0000);
        chk("midrst_valid", ir_valid, 1'b0);
        chk("midrst_req2", imem_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
